scoreboard_hazard: RTL and testbench

Parametrised successor to the single-cycle load-use detector in the pipeline CPU. It tracks a per-register countdown of cycles until each pending result becomes forwardable, so that loads, multi-cycle MUL/DIV and any future variable-latency unit stall dependent instructions exactly as long as needed. It sits beside the ID stage, consumes the decoded ID instruction plus an EX-stage flush, and drives PC write-enable, IF/ID hold and the ID/EX bubble.

---
 rtl/scoreboard_hazard_if.sv | 75 +++++++
 rtl/scoreboard_hazard.sv | 161 ++++++++++++++++
 tb/tb_scoreboard_hazard.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scoreboard_hazard_if.sv
// ----------------------------------------------------------------------------
// scoreboard_hazard_if
//   Groups the ID-stage request and pipeline-control response of the hazard
//   scoreboard into one bundle.
//
//   Parameters
//     ADDR_W : register address width
//     LAT_W  : latency field width
//
//   Signals (the _i/_o suffixes are named from the scoreboard's side)
//     ID_Valid_i            ID holds a real instruction
//     ID_Rs1_i / ID_Rs2_i   source register addresses
//     ID_Use1_i / ID_Use2_i the corresponding source is actually read
//     ID_Rd_i               destination register
//     ID_RegWrite_i         ID instruction writes ID_Rd_i
//     ID_Lat_i              cycles after issue until the result is forwardable
//     Flush_i               kill the instructions in EX and ID this cycle
//     PCWrite_o             PC may advance
//     Stall_o               hold IF/ID
//     NoOp_o                insert a bubble into ID/EX
//
//   Modports
//     master : the ID stage / pipeline control that drives the request
//     slave  : the scoreboard itself
// ----------------------------------------------------------------------------
interface scoreboard_hazard_if #(
  parameter int ADDR_W = 5,
  parameter int LAT_W  = 3
);

  logic              ID_Valid_i;
  logic [ADDR_W-1:0] ID_Rs1_i;
  logic [ADDR_W-1:0] ID_Rs2_i;
  logic              ID_Use1_i;
  logic              ID_Use2_i;
  logic [ADDR_W-1:0] ID_Rd_i;
  logic              ID_RegWrite_i;
  logic [LAT_W-1:0]  ID_Lat_i;
  logic              Flush_i;

  logic              PCWrite_o;
  logic              Stall_o;
  logic              NoOp_o;

  modport master (
    output ID_Valid_i,
    output ID_Rs1_i,
    output ID_Rs2_i,
    output ID_Use1_i,
    output ID_Use2_i,
    output ID_Rd_i,
    output ID_RegWrite_i,
    output ID_Lat_i,
    output Flush_i,
    input  PCWrite_o,
    input  Stall_o,
    input  NoOp_o
  );

  modport slave (
    input  ID_Valid_i,
    input  ID_Rs1_i,
    input  ID_Rs2_i,
    input  ID_Use1_i,
    input  ID_Use2_i,
    input  ID_Rd_i,
    input  ID_RegWrite_i,
    input  ID_Lat_i,
    input  Flush_i,
    output PCWrite_o,
    output Stall_o,
    output NoOp_o
  );

endinterface

// File: rtl/scoreboard_hazard.sv
// ----------------------------------------------------------------------------
// scoreboard_hazard
//   Per-register latency scoreboard for the in-order pipeline. Every tracked
//   register carries a countdown of cycles until its pending result can be
//   forwarded. An ID instruction stalls while any source it reads is still
//   counting (RAW), or while an older, slower write to its destination would
//   complete after it (WAW). A flush of EX undoes the counter that the EX
//   instruction set when it issued.
//
//   Parameters
//     ADDR_W : register address width (NUM_REGS = 2**ADDR_W, x0 never tracked)
//     LAT_W  : latency field width (max latency 2**LAT_W-1)
//     Both must match the parameters of the connected interface instance.
//
//   Ports
//     clk_i       clock, rising edge
//     rst_i       asynchronous, active-low reset
//     sb          scoreboard_hazard_if.slave (ID request, pipeline control)
//     PerfClr_i   synchronous clear of the stall counter      (perf build)
//     StallCnt_o  free-running count of stall cycles, 32 bit  (perf build)
//
//   Build option
//     SCOREBOARD_PERF_EN : when defined, adds PerfClr_i / StallCnt_o and the
//                          stall-cycle counter. Hazard behaviour is the same
//                          in both builds.
// ----------------------------------------------------------------------------
module scoreboard_hazard #(
  parameter int ADDR_W = 5,
  parameter int LAT_W  = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  scoreboard_hazard_if.slave sb
`ifdef SCOREBOARD_PERF_EN
  ,
  input  logic               PerfClr_i,
  output logic [31:0]        StallCnt_o
`endif
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  // Countdown that never wraps below zero.
  function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] v);
    return (v == '0) ? '0 : v - LAT_W'(1);
  endfunction

  // --------------------------------------------------------------------------
  // State
  //   cnt_q[r]  : cycles until register r becomes forwardable (entry 0 stays 0)
  //   ex_*_q    : what the instruction now in EX did to the scoreboard, so a
  //               flush can put its destination counter back
  // --------------------------------------------------------------------------
  logic [NUM_REGS-1:0][LAT_W-1:0] cnt_q, cnt_d;
  logic                           ex_v_q, ex_v_d;
  logic [ADDR_W-1:0]              ex_rd_q, ex_rd_d;
  logic [LAT_W-1:0]               ex_prev_q, ex_prev_d;

  // --------------------------------------------------------------------------
  // Hazard detection, purely combinational from the current counters
  // --------------------------------------------------------------------------
  logic             raw1, raw2, waw;
  logic             stall, issue, track, restore;
  logic [LAT_W-1:0] rd_cnt;

  assign rd_cnt = cnt_q[sb.ID_Rd_i];

  assign raw1 = sb.ID_Use1_i && (sb.ID_Rs1_i != '0) && (cnt_q[sb.ID_Rs1_i] != '0);
  assign raw2 = sb.ID_Use2_i && (sb.ID_Rs2_i != '0) && (cnt_q[sb.ID_Rs2_i] != '0);

  // A younger write may only issue once it cannot finish ahead of the older
  // one, i.e. the pending count is no larger than its own latency.
  assign waw  = sb.ID_RegWrite_i && (sb.ID_Rd_i != '0) && (rd_cnt > sb.ID_Lat_i);

  // A flush forces the stall low: the pipeline supplies its own bubble for
  // the killed ID slot, and nothing issues.
  assign stall   = sb.ID_Valid_i && !sb.Flush_i && (raw1 || raw2 || waw);
  assign issue   = sb.ID_Valid_i && !stall && !sb.Flush_i;

  // Only non-zero-latency writes to a real register occupy a counter.
  assign track   = issue && sb.ID_RegWrite_i && (sb.ID_Rd_i != '0) && (sb.ID_Lat_i != '0);
  assign restore = sb.Flush_i && ex_v_q;

  assign sb.Stall_o   = stall;
  assign sb.NoOp_o    = stall;
  assign sb.PCWrite_o = !stall;

  // --------------------------------------------------------------------------
  // Next-state: flush restore > issue set > decrement
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    cnt_d = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      cnt_d[r] = sat_dec(cnt_q[r]);
      if (track && (sb.ID_Rd_i == ADDR_W'(r))) begin
        cnt_d[r] = sb.ID_Lat_i;
      end
      // ex_prev_q already holds the value one cycle after the EX issue;
      // one more cycle has passed by the time the flush takes effect.
      if (restore && (ex_rd_q == ADDR_W'(r))) begin
        cnt_d[r] = sat_dec(ex_prev_q);
      end
    end
  end

  // Shadow of the instruction moving into EX: the counter value its
  // destination would have had without it.
  assign ex_v_d    = track;
  assign ex_rd_d   = sb.ID_Rd_i;
  assign ex_prev_d = sat_dec(rd_cnt);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // NOTE: the counter array is a bank of flops, not a RAM macro, so resetting
  // every entry is cheap and required for the all-idle reset state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q     <= '0;
      ex_v_q    <= 1'b0;
      ex_rd_q   <= '0;
      ex_prev_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      cnt_q     <= cnt_d;
      ex_v_q    <= ex_v_d;
      ex_rd_q   <= ex_rd_d;
      ex_prev_q <= ex_prev_d;
    end
  end

`ifdef SCOREBOARD_PERF_EN
  // --------------------------------------------------------------------------
  // Stall-cycle counter; clear takes precedence over increment, wraps at 2^32
  // --------------------------------------------------------------------------
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (PerfClr_i) begin
      stall_cnt_d = '0;
    end else if (stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_scoreboard_hazard.sv
// ----------------------------------------------------------------------------
// tb_scoreboard_hazard
//   Directed bench for scoreboard_hazard. The reference model keeps, per
//   register, the absolute cycle at which its result becomes forwardable; the
//   remaining count is that time minus the current cycle, floored at zero. A
//   flush puts back the ready time the destination had before the EX issue.
//   A compare process checks the control outputs and every counter against
//   the model on each falling edge; directed sequences add hand-computed
//   stall counts and counter values.
//   Define SCOREBOARD_PERF_EN for both RTL and bench to cover the counter.
// ----------------------------------------------------------------------------
module tb_scoreboard_hazard;

  localparam int ADDR_W   = 5;
  localparam int LAT_W    = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic clk   = 1'b0;
  logic rst_i = 1'b0;

  always #5 clk = ~clk;

  scoreboard_hazard_if #(.ADDR_W(ADDR_W), .LAT_W(LAT_W)) sbi ();

`ifdef SCOREBOARD_PERF_EN
  logic        perf_clr = 1'b0;
  logic [31:0] stall_cnt;
`endif

  scoreboard_hazard #(.ADDR_W(ADDR_W), .LAT_W(LAT_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .sb         (sbi)
`ifdef SCOREBOARD_PERF_EN
    ,
    .PerfClr_i  (perf_clr),
    .StallCnt_o (stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // --------------------------------------------------------------------------
  // Reference model: absolute ready times
  // --------------------------------------------------------------------------
  int ready_at [NUM_REGS];
  int cyc     = 0;
  bit exm_v   = 1'b0;
  int exm_rd  = 0;
  int exm_old = 0;
  bit m_iss;
  int m_rd;

  function automatic int cnt_m(input int r);
    int v;
    if (r == 0) return 0;
    v = ready_at[r] - cyc;
    return (v > 0) ? v : 0;
  endfunction

  function automatic bit stall_m();
    bit raw, waw;
    raw = (sbi.ID_Use1_i && cnt_m(int'(sbi.ID_Rs1_i)) > 0) ||
          (sbi.ID_Use2_i && cnt_m(int'(sbi.ID_Rs2_i)) > 0);
    waw = sbi.ID_RegWrite_i && (cnt_m(int'(sbi.ID_Rd_i)) > int'(sbi.ID_Lat_i));
    return sbi.ID_Valid_i && !sbi.Flush_i && (raw || waw);
  endfunction

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) ready_at[r] = 0;
      exm_v = 1'b0;
    end else begin
      m_iss = sbi.ID_Valid_i && !stall_m() && !sbi.Flush_i;
      m_rd  = int'(sbi.ID_Rd_i);
      if (sbi.Flush_i && exm_v) ready_at[exm_rd] = exm_old;
      if (m_iss && sbi.ID_RegWrite_i && m_rd != 0 && sbi.ID_Lat_i != '0) begin
        exm_v        = 1'b1;
        exm_rd       = m_rd;
        exm_old      = ready_at[m_rd];
        ready_at[m_rd] = cyc + 1 + int'(sbi.ID_Lat_i);
      end else begin
        exm_v = 1'b0;
      end
      cyc++;
    end
  end

  // Compare process: outputs and the whole counter bank on every falling edge
  logic [NUM_REGS*LAT_W-1:0] mv;
  always @(negedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) mv[r*LAT_W +: LAT_W] = LAT_W'(cnt_m(r));
    check("model stall",   128'(sbi.Stall_o),   128'(stall_m()));
    check("model noop",    128'(sbi.NoOp_o),    128'(stall_m()));
    check("model pcwrite", 128'(sbi.PCWrite_o), 128'(!stall_m()));
    check("model cnt",     128'(dut.cnt_q),     128'(mv));
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // --------------------------------------------------------------------------
  task automatic clear_id();
    sbi.ID_Valid_i    = 1'b0;
    sbi.ID_Rs1_i      = '0;
    sbi.ID_Rs2_i      = '0;
    sbi.ID_Use1_i     = 1'b0;
    sbi.ID_Use2_i     = 1'b0;
    sbi.ID_Rd_i       = '0;
    sbi.ID_RegWrite_i = 1'b0;
    sbi.ID_Lat_i      = '0;
    sbi.Flush_i       = 1'b0;
  endtask

  task automatic set_id(input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit rw, input int lat);
    sbi.ID_Valid_i    = 1'b1;
    sbi.ID_Rs1_i      = ADDR_W'(rs1);
    sbi.ID_Use1_i     = u1;
    sbi.ID_Rs2_i      = ADDR_W'(rs2);
    sbi.ID_Use2_i     = u2;
    sbi.ID_Rd_i       = ADDR_W'(rd);
    sbi.ID_RegWrite_i = rw;
    sbi.ID_Lat_i      = LAT_W'(lat);
    sbi.Flush_i       = 1'b0;
  endtask

  task automatic idle(input int n);
    clear_id();
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one instruction, count its stall cycles (bounded), let it issue.
  task automatic send(input string name, input int rs1, input bit u1, input int rs2,
                      input bit u2, input int rd, input bit rw, input int lat,
                      input int exp_stalls);
    int stalls;
    stalls = 0;
    set_id(rs1, u1, rs2, u2, rd, rw, lat);
    #1;
    while (sbi.Stall_o === 1'b1 && stalls < 20) begin
      stalls++;
      @(posedge clk); #1;
    end
    check(name, 128'(stalls), 128'(exp_stalls));
    @(posedge clk); #1;
    clear_id();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    int exp;
    clear_id();

    // Reset held with ID reading x5
    set_id(5, 1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset stall",   128'(sbi.Stall_o),   128'(0));
    check("reset pcwrite", 128'(sbi.PCWrite_o), 128'(1));
    check("reset noop",    128'(sbi.NoOp_o),    128'(0));
    #2 rst_i = 1'b1;
    @(posedge clk); #1;
    clear_id();
    check("cnt after reset", 128'(dut.cnt_q), 128'(0));

    // Load-use: one stall
    send("lw x5",          0, 0, 0, 0, 5, 1, 1, 0);
    send("add x6,x5,x7",   5, 1, 7, 1, 6, 1, 0, 1);
    idle(8);

    // Load, independent op, use: no stall
    send("lw x5 b",        0, 0, 0, 0, 5, 1, 1, 0);
    send("addi x1,x2",     2, 1, 0, 0, 1, 1, 0, 0);
    send("add x6,x5 gap",  5, 1, 7, 1, 6, 1, 0, 0);
    idle(8);

    // Multi-cycle producer: four stalls
    send("mul x8",         0, 0, 0, 0, 8, 1, 4, 0);
    send("use x8",         8, 1, 0, 0, 3, 1, 0, 4);
    idle(8);

    // rs2 named but not read
    send("mul x8 b",       0, 0, 0, 0, 8, 1, 4, 0);
    send("rs2 x8 unused",  0, 1, 8, 0, 3, 1, 0, 0);
    idle(8);

    // WAW behind a slower write
    send("mul x9",         0, 0, 0, 0, 9, 1, 4, 0);
    send("addi x9 waw",    1, 1, 0, 0, 9, 1, 0, 4);
    idle(8);

    // x0 is never tracked
    send("mul x0",         0, 0, 0, 0, 0, 1, 4, 0);
    send("addi x0 waw",    0, 1, 0, 1, 0, 1, 0, 0);
    idle(8);

    // div x10, two cycles later lw x10 (WAW until count <= 1), then flush
    send("div x10",        0, 0, 0, 0, 10, 1, 6, 0);
    idle(1);
    send("lw x10 waw",     0, 0, 0, 0, 10, 1, 1, 4);
    set_id(1, 1, 0, 0, 13, 1, 3);
    sbi.Flush_i = 1'b1;
    #1;
    check("flush free id stall",   128'(sbi.Stall_o),   128'(0));
    check("flush free id pcwrite", 128'(sbi.PCWrite_o), 128'(1));
    @(posedge clk); #1;
    clear_id();
    check("restore x10",           128'(dut.cnt_q[10]), 128'(0));
    check("flushed id not issued", 128'(dut.cnt_q[13]), 128'(0));
    idle(8);

    // Restore to a non-zero older value
    send("div x11",        0, 0, 0, 0, 11, 1, 6, 0);
    send("mul x11 waw",    0, 0, 0, 0, 11, 1, 4, 2);
    set_id(11, 1, 0, 0, 12, 1, 2);
    sbi.Flush_i = 1'b1;
    #1;
    check("flush hazard id stall", 128'(sbi.Stall_o), 128'(0));
    @(posedge clk); #1;
    clear_id();
    check("restore x11",           128'(dut.cnt_q[11]), 128'(2));
    check("flushed x12 untouched", 128'(dut.cnt_q[12]), 128'(0));
    sbi.Flush_i = 1'b1;
    @(posedge clk); #1;
    clear_id();
    check("flush no ex x11",       128'(dut.cnt_q[11]), 128'(1));
    idle(8);

    // Stall = max(0, L-N+1) for a consumer N cycles after the producer
    for (int lat = 1; lat < 8; lat++) begin
      for (int n = 1; n <= 3; n++) begin
        exp = lat - n + 1;
        if (exp < 0) exp = 0;
        send($sformatf("sweep prod L%0d", lat), 0, 0, 0, 0, 20, 1, lat, 0);
        if (n > 1) idle(n - 1);
        send($sformatf("sweep use L%0d N%0d", lat, n), 0, 0, 20, 1, 21, 1, 0, exp);
        idle(8);
      end
    end

`ifdef SCOREBOARD_PERF_EN
    perf_clr = 1'b1;
    @(posedge clk); #1;
    perf_clr = 1'b0;
    check("perf cleared", 128'(stall_cnt), 128'(0));
    send("mul x14",        0, 0, 0, 0, 14, 1, 5, 0);
    send("use x14",        14, 1, 0, 0, 15, 1, 0, 5);
    check("perf count 5", 128'(stall_cnt), 128'(5));
    send("mul x14 b",      0, 0, 0, 0, 14, 1, 5, 0);
    set_id(14, 1, 0, 0, 15, 1, 0);
    @(posedge clk); #1;
    perf_clr = 1'b1;
    @(posedge clk); #1;
    perf_clr = 1'b0;
    check("perf clr in stall", 128'(stall_cnt), 128'(0));
    idle(8);
`endif

    // Reset asserted mid-stall clears immediately
    send("mul x5 L6",      0, 0, 0, 0, 5, 1, 6, 0);
    set_id(5, 1, 0, 0, 6, 1, 0);
    #1;
    check("pre-reset stall", 128'(sbi.Stall_o), 128'(1));
    #1 rst_i = 1'b0;
    #1;
    check("async reset stall",   128'(sbi.Stall_o),   128'(0));
    check("async reset pcwrite", 128'(sbi.PCWrite_o), 128'(1));
    check("async reset cnt",     128'(dut.cnt_q),     128'(0));
    clear_id();
    @(posedge clk);
    #2 rst_i = 1'b1;
    @(posedge clk); #1;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
